// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps one instruction request in flight, drops stale
// responses after a redirect, and hands {pc, inst} to decode through a one-entry buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        buf_valid_q, buf_valid_d;
    logic        drain, accept, fill;

    // A new request is only launched when its response is guaranteed a free buffer slot.
    assign drain    = buf_valid_q && id_ready;
    assign inst_req = reset && (state_q == S_REQ) && !br_taken && (!buf_valid_q || drain);
    assign accept   = inst_req && inst_addr_ok;
    assign fill     = (state_q == S_WAIT) && inst_data_ok && !br_taken;

    assign inst_addr = pc_q;
    assign id_valid  = buf_valid_q;
    assign id_bus    = {buf_pc_q, buf_inst_q};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;

        if (br_taken) begin
            pc_d        = br_target & ~32'h3;
            buf_valid_d = 1'b0;
        end else if (accept) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end

        if (fill) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = req_pc_q;
            buf_inst_d  = inst_rdata;
        end else if (drain && !br_taken) begin
            buf_valid_d = 1'b0;
        end

        // A response still owed after a redirect must be swallowed in DISCARD.
        case (state_q)
            S_REQ:     if (accept) state_d = S_WAIT;
            S_WAIT: begin
                if (inst_data_ok)  state_d = S_REQ;
                else if (br_taken) state_d = S_DISCARD;
            end
            S_DISCARD: if (inst_data_ok) state_d = S_REQ;
            default:   state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= 32'h0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= 32'h0;
            buf_inst_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
        end
    end
endmodule
